// File: rtl/axi_isolate_seq_pkg.sv
// rtl/axi_isolate_seq_pkg.sv - state encoding and helpers for the AXI isolation sequencer
package axi_isolate_seq_pkg;

  typedef enum logic [2:0] {
    CONNECTED   = 3'd0,
    ISOLATING   = 3'd1,
    ISOLATED    = 3'd2,
    RST_ASSERT  = 3'd3,
    RST_RELEASE = 3'd4,
    DEISOLATING = 3'd5
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/axi_isolate_sequencer.sv
// rtl/axi_isolate_sequencer.sv - sequences isolation, clock gating and reset of a downstream AXI domain
module axi_isolate_sequencer
  import axi_isolate_seq_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 32'd1024,
  parameter int unsigned RstHoldCycles = 32'd16,
  parameter int unsigned SettleCycles  = 32'd4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       isolate_req_i,
  input  logic       reset_req_i,
  input  logic       isolated_i,
  output logic       isolate_o,
  output logic       clk_en_o,
  output logic       domain_rst_no,
  output logic       busy_o,
  output logic       timeout_o,
  output logic [2:0] state_o
);

  localparam int unsigned MaxCycles = max3(TimeoutCycles, RstHoldCycles, SettleCycles);
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam bit          TimeoutEn = (TimeoutCycles != 0);

  localparam logic [CntW-1:0] TimeoutCnt    = CntW'(TimeoutCycles);
  localparam logic [CntW-1:0] RstLastCnt    = CntW'(RstHoldCycles - 1);
  localparam logic [CntW-1:0] SettleCnt     = CntW'(SettleCycles);
  localparam logic [CntW-1:0] SettleLastCnt = CntW'(SettleCycles - 1);

  if (RstHoldCycles == 0) begin : g_bad_rst_hold
    $error("RstHoldCycles must be at least 1");
  end
  if (SettleCycles == 0) begin : g_bad_settle
    $error("SettleCycles must be at least 1");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rst_pend_q, rst_pend_d;
  logic              timeout_q, timeout_d;
  logic              rst_req_ok;
  logic              pend_now;
  logic              iso_hold;

  // Reset pulses are ignored while a domain reset is already underway.
  assign rst_req_ok = reset_req_i && (state_q != RST_ASSERT) && (state_q != RST_RELEASE);
  assign pend_now   = rst_pend_q || rst_req_ok;
  assign iso_hold   = (cnt_q < SettleCnt);

  always_comb begin
    state_d    = state_q;
    timeout_d  = timeout_q;
    rst_pend_d = pend_now;
    case (state_q)
      CONNECTED: begin
        if (isolate_req_i || pend_now) begin
          state_d   = ISOLATING;
          timeout_d = 1'b0;
        end
      end
      ISOLATING: begin
        if (TimeoutEn && (cnt_q == TimeoutCnt)) timeout_d = 1'b1;
        if (isolated_i) state_d = ISOLATED;
        else if (!isolate_req_i && !pend_now) state_d = DEISOLATING;
      end
      ISOLATED: begin
        if (pend_now) state_d = RST_ASSERT;
        else if (!isolate_req_i) state_d = DEISOLATING;
      end
      RST_ASSERT: begin
        if (cnt_q == RstLastCnt) state_d = RST_RELEASE;
      end
      RST_RELEASE: begin
        if (cnt_q == SettleLastCnt) begin
          state_d    = isolate_req_i ? ISOLATED : DEISOLATING;
          rst_pend_d = 1'b0;
        end
      end
      DEISOLATING: begin
        if (!iso_hold && !isolated_i) state_d = CONNECTED;
      end
      default: state_d = CONNECTED;
    endcase
  end

  always_comb begin
    if (state_d != state_q) cnt_d = '0;
    else if (&cnt_q)        cnt_d = cnt_q;
    else                    cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= CONNECTED;
      cnt_q      <= '0;
      rst_pend_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_pend_q <= rst_pend_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    isolate_o     = 1'b1;
    clk_en_o      = 1'b1;
    domain_rst_no = 1'b1;
    busy_o        = 1'b1;
    case (state_q)
      CONNECTED: begin
        isolate_o = 1'b0;
        busy_o    = 1'b0;
      end
      ISOLATED: begin
        clk_en_o = 1'b0;
        busy_o   = 1'b0;
      end
      RST_ASSERT:  domain_rst_no = 1'b0;
      DEISOLATING: isolate_o     = iso_hold;
      default: ;
    endcase
  end

  assign timeout_o = timeout_q;
  assign state_o   = state_q;

  // The stage must hold isolated_o for as long as we keep the domain gated.
  isolated_held_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == ISOLATED) |-> isolated_i);

endmodule

// File: tb/tb_axi_isolate_sequencer.sv
// tb/tb_axi_isolate_sequencer.sv - self-checking bench for axi_isolate_sequencer
module tb_axi_isolate_sequencer;
  import axi_isolate_seq_pkg::*;

  localparam int TO = 8;
  localparam int RH = 16;
  localparam int ST = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       isolate_req, reset_req, isolated;
  logic       isolate_o, clk_en, dom_rst_n, busy, tout;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  state_e m_st   = CONNECTED;
  int     m_age  = 0;
  bit     m_pend = 1'b0;
  bit     m_tout = 1'b0;

  axi_isolate_sequencer #(
    .TimeoutCycles(TO),
    .RstHoldCycles(RH),
    .SettleCycles (ST)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .isolate_req_i(isolate_req),
    .reset_req_i  (reset_req),
    .isolated_i   (isolated),
    .isolate_o    (isolate_o),
    .clk_en_o     (clk_en),
    .domain_rst_no(dom_rst_n),
    .busy_o       (busy),
    .timeout_o    (tout),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stays in a phase, ages, and moves on by the documented rules.
  task automatic model_step();
    state_e nxt;
    bit     pend;
    if (!rst_n) begin
      m_st = CONNECTED; m_age = 0; m_pend = 1'b0; m_tout = 1'b0;
      return;
    end
    nxt  = m_st;
    pend = m_pend || (reset_req && !(m_st inside {RST_ASSERT, RST_RELEASE}));
    case (m_st)
      CONNECTED:   if (isolate_req || pend) begin nxt = ISOLATING; m_tout = 1'b0; end
      ISOLATING: begin
        if (TO != 0 && m_age == TO) m_tout = 1'b1;
        if (isolated) nxt = ISOLATED;
        else if (!isolate_req && !pend) nxt = DEISOLATING;
      end
      ISOLATED:    nxt = pend ? RST_ASSERT : (!isolate_req ? DEISOLATING : ISOLATED);
      RST_ASSERT:  if (m_age == RH - 1) nxt = RST_RELEASE;
      RST_RELEASE: if (m_age == ST - 1) begin
        nxt  = isolate_req ? ISOLATED : DEISOLATING;
        pend = 1'b0;
      end
      default:     if (m_age >= ST && !isolated) nxt = CONNECTED;
    endcase
    m_pend = pend;
    m_age  = (nxt == m_st) ? m_age + 1 : 0;
    m_st   = nxt;
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  always @(negedge clk) begin
    chk("cmp_state", state, m_st);
    chk("cmp_isolate", isolate_o, (m_st == DEISOLATING) ? (m_age < ST) : (m_st != CONNECTED));
    chk("cmp_clk_en", clk_en, m_st != ISOLATED);
    chk("cmp_dom_rst_n", dom_rst_n, m_st != RST_ASSERT);
    chk("cmp_busy", busy, !(m_st inside {CONNECTED, ISOLATED}));
    chk("cmp_timeout", tout, m_tout);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_iso_low(input string name);
    int k = 0;
    while (isolate_o !== 1'b0 && k < 20) begin tick(); k++; end
    chk(name, isolate_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; isolate_req = 1'b0; reset_req = 1'b0; isolated = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, CONNECTED);
    chk("rst_isolate", isolate_o, 0);
    chk("rst_clk_en", clk_en, 1);
    chk("rst_dom", dom_rst_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", tout, 0);
    rst_n = 1'b1;
    tick();

    // isolate and release
    isolate_req = 1'b1; tick();
    chk("ir_isolate_after_req", isolate_o, 1);
    chk("ir_state", state, ISOLATING);
    repeat (4) tick();
    isolated = 1'b1; tick();
    chk("ir_gated", clk_en, 0);
    chk("ir_isolated", state, ISOLATED);
    isolate_req = 1'b0; tick();
    chk("ir_clk_back", clk_en, 1);
    n = 0;
    while (isolate_o === 1'b1 && n < 20) begin tick(); n++; end
    chk("ir_iso_hold_len", n, 4);
    isolated = 1'b0; tick();
    chk("ir_connected", state, CONNECTED);

    // single reset pulse
    reset_req = 1'b1; tick(); reset_req = 1'b0;
    chk("rp_isolating", state, ISOLATING);
    isolated = 1'b1; tick();
    chk("rp_isolated", state, ISOLATED);
    tick();
    chk("rp_rst_assert", state, RST_ASSERT);
    n = 0;
    while (dom_rst_n === 1'b0 && n < 50) begin tick(); n++; end
    chk("rp_rst_low_len", n, 16);
    n = 0;
    while (state === RST_RELEASE && n < 50) begin tick(); n++; end
    chk("rp_settle_len", n, 4);
    chk("rp_deisolating", state, DEISOLATING);
    wait_iso_low("rp_iso_low");
    isolated = 1'b0; tick();
    chk("rp_connected", state, CONNECTED);
    tick();
    chk("rp_stays_connected", state, CONNECTED);

    // isolation timeout
    isolate_req = 1'b1; tick();
    n = 0;
    while (tout === 1'b0 && n < 40) begin tick(); n++; end
    chk("to_latency", n, 9);
    chk("to_clk_en", clk_en, 1);
    repeat (3) tick();
    chk("to_still_isolating", state, ISOLATING);
    isolated = 1'b1; tick();
    chk("to_isolated", state, ISOLATED);
    isolate_req = 1'b0; tick();
    wait_iso_low("to_iso_low");
    isolated = 1'b0; tick();
    chk("to_connected", state, CONNECTED);
    chk("to_sticky", tout, 1);

    // abort before isolated_i
    isolate_req = 1'b1; tick();
    chk("ab_timeout_cleared", tout, 0);
    repeat (2) tick();
    isolate_req = 1'b0; tick();
    chk("ab_deisolating", state, DEISOLATING);
    n = 0;
    while (state !== CONNECTED && n < 20) begin tick(); n++; end
    chk("ab_return_len", n, 5);

    // reset request arriving during de-isolation
    isolate_req = 1'b1; tick();
    isolated = 1'b1; tick();
    isolate_req = 1'b0; tick();
    reset_req = 1'b1; tick(); reset_req = 1'b0;
    wait_iso_low("lr_iso_low");
    isolated = 1'b0; tick();
    chk("lr_connected", state, CONNECTED);
    tick();
    chk("lr_reisolate", state, ISOLATING);
    isolated = 1'b1; tick(); tick();
    chk("lr_rst_assert", state, RST_ASSERT);
    n = 0;
    while (dom_rst_n === 1'b0 && n < 50) begin tick(); n++; end
    chk("lr_rst_low_len", n, 16);
    n = 0;
    while (state === RST_RELEASE && n < 50) begin tick(); n++; end
    wait_iso_low("lr_iso_low2");
    isolated = 1'b0; tick();
    chk("lr_done", state, CONNECTED);

    // simultaneous isolate and reset requests
    isolate_req = 1'b1; reset_req = 1'b1; tick(); reset_req = 1'b0;
    isolated = 1'b1; tick(); tick();
    chk("sim_rst_assert", state, RST_ASSERT);
    n = 0;
    while (dom_rst_n === 1'b0 && n < 50) begin tick(); n++; end
    n = 0;
    while (state === RST_RELEASE && n < 50) begin tick(); n++; end
    chk("sim_back_isolated", state, ISOLATED);
    repeat (3) tick();
    chk("sim_stays_isolated", state, ISOLATED);
    chk("sim_gated", clk_en, 0);

    // asynchronous reset in the middle of RST_ASSERT
    reset_req = 1'b1; tick(); reset_req = 1'b0;
    chk("ar_rst_assert", state, RST_ASSERT);
    repeat (3) tick();
    #3;
    rst_n = 1'b0; isolated = 1'b0; isolate_req = 1'b0;
    #1;
    chk("ar_state", state, CONNECTED);
    chk("ar_isolate", isolate_o, 0);
    chk("ar_clk_en", clk_en, 1);
    chk("ar_dom", dom_rst_n, 1);
    chk("ar_busy", busy, 0);
    chk("ar_timeout", tout, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("ar_idle", state, CONNECTED);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
